// File: rtl/mips_cpu_bus_core.sv
// Multi-cycle MIPS-I subset CPU with a single Avalon-MM master port shared
// by instruction fetch and data access; halts after control reaches address 0.
module mips_cpu_bus_core #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    // Bus handshake: a request (read or write) is held with address, writedata
    // and byteenable stable until a cycle with waitrequest=0 completes it.
    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic        run_q;
    logic [31:0] pc_q, ir_q, npc_q, res_q, mem_addr_q, br_target_q;
    logic [4:0]  dst_q;
    logic        wen_q, load_q, store_q, br_pending_q;
    logic [31:0] rf [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [31:0] rs_val, rt_val, simm, zimm, pc_plus4, pc_plus8, npc, mem_addr, sum;
    logic [31:0] res, target;
    logic [4:0]  dst;
    logic        wen, ld, st, taken;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign sh       = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];
    assign rs_val   = rf[rs];
    assign rt_val   = rf[rt];
    assign simm     = {{16{imm[15]}}, imm};
    assign zimm     = {16'h0000, imm};
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_plus8 = pc_q + 32'd8;
    assign sum      = rs_val + simm;
    assign mem_addr = {sum[31:2], 2'b00};
    // A pending branch redirects the instruction after the delay slot.
    assign npc      = br_pending_q ? br_target_q : pc_plus4;

    always_comb begin
        res    = 32'h0;
        dst    = 5'd0;
        wen    = 1'b0;
        ld     = 1'b0;
        st     = 1'b0;
        taken  = 1'b0;
        target = 32'h0;
        case (op)
            6'h00: begin
                dst = rd;
                wen = 1'b1;
                case (funct)
                    6'h21: res = rs_val + rt_val;
                    6'h23: res = rs_val - rt_val;
                    6'h24: res = rs_val & rt_val;
                    6'h25: res = rs_val | rt_val;
                    6'h26: res = rs_val ^ rt_val;
                    6'h27: res = ~(rs_val | rt_val);
                    6'h2A: res = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B: res = {31'h0, rs_val < rt_val};
                    6'h00: res = rt_val << sh;
                    6'h02: res = rt_val >> sh;
                    6'h03: res = $signed(rt_val) >>> sh;
                    6'h04: res = rt_val << rs_val[4:0];
                    6'h06: res = rt_val >> rs_val[4:0];
                    6'h07: res = $signed(rt_val) >>> rs_val[4:0];
                    6'h08: begin
                        wen    = 1'b0;
                        taken  = 1'b1;
                        target = rs_val;
                    end
                    6'h09: begin
                        res    = pc_plus8;
                        taken  = 1'b1;
                        target = rs_val;
                    end
                    default: wen = 1'b0;
                endcase
            end
            6'h02, 6'h03: begin
                taken  = 1'b1;
                target = {pc_plus4[31:28], ir_q[25:0], 2'b00};
                if (op == 6'h03) begin
                    dst = 5'd31;
                    wen = 1'b1;
                    res = pc_plus8;
                end
            end
            6'h04, 6'h05: begin
                taken  = (rs_val == rt_val) ^ (op == 6'h05);
                target = pc_plus4 + (simm << 2);
            end
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                dst = rt;
                wen = 1'b1;
                case (op)
                    6'h09:   res = sum;
                    6'h0A:   res = {31'h0, $signed(rs_val) < $signed(simm)};
                    6'h0B:   res = {31'h0, rs_val < simm};
                    6'h0C:   res = rs_val & zimm;
                    6'h0D:   res = rs_val | zimm;
                    6'h0E:   res = rs_val ^ zimm;
                    default: res = {imm, 16'h0000};
                endcase
            end
            6'h23: begin
                dst = rt;
                wen = 1'b1;
                ld  = 1'b1;
            end
            6'h2B: st = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (run_q && !waitrequest) state_d = S_EXEC;
            S_EXEC:  state_d = (ld || st) ? S_MEM : S_WB;
            S_MEM:   if (!waitrequest) state_d = S_WB;
            S_WB:    state_d = (npc_q == 32'h0) ? S_HALT : S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // run_q keeps the bus idle during the reset cycle itself.
    assign read        = (state_q == S_FETCH && run_q) || (state_q == S_MEM && load_q);
    assign write       = (state_q == S_MEM) && store_q;
    assign address     = (state_q == S_MEM) ? mem_addr_q : pc_q;
    assign byteenable  = 4'b1111;
    assign active      = (state_q != S_HALT);
    assign register_v0 = rf[2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            run_q        <= 1'b0;
            pc_q         <= RESET_VECTOR;
            ir_q         <= 32'h0;
            npc_q        <= 32'h0;
            res_q        <= 32'h0;
            mem_addr_q   <= 32'h0;
            br_target_q  <= 32'h0;
            dst_q        <= 5'd0;
            wen_q        <= 1'b0;
            load_q       <= 1'b0;
            store_q      <= 1'b0;
            br_pending_q <= 1'b0;
            writedata    <= 32'h0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            case (state_q)
                S_FETCH: if (run_q && !waitrequest) ir_q <= readdata;
                S_EXEC: begin
                    res_q        <= res;
                    dst_q        <= dst;
                    wen_q        <= wen;
                    load_q       <= ld;
                    store_q      <= st;
                    mem_addr_q   <= mem_addr;
                    npc_q        <= npc;
                    br_pending_q <= taken;
                    br_target_q  <= target;
                    if (st) writedata <= rt_val;
                end
                S_MEM: if (!waitrequest && load_q) res_q <= readdata;
                S_WB: begin
                    if (wen_q && dst_q != 5'd0) rf[dst_q] <= res_q;
                    pc_q <= npc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// Directed bench for mips_cpu_bus_core: word RAM slave with optional stalls,
// small hand-assembled programs, immediate-assertion checks.
module tb_mips_cpu_bus_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        active, write, read, waitrequest;
    logic [31:0] register_v0, address, writedata, readdata;
    logic [3:0]  byteenable;

    logic [31:0] prog [16];
    logic [31:0] dmem [64];
    logic        stall_en = 1'b0;
    logic        hold_wait = 1'b0;
    logic        mon_en = 1'b0;
    int          wait_cnt = 0;
    int          wr_count = 0;
    logic [31:0] wr_addr = 32'h0, wr_data = 32'h0;
    int          unstable = 0, overlap = 0, post_halt = 0, stall_cnt = 0;
    logic        prev_wait = 1'b0, prev_read = 1'b0, prev_write = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_wd = 32'h0;

    int errors = 0;
    int checks = 0;
    int cyc;
    int snap;

    always #5 clk = ~clk;

    mips_cpu_bus_core dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    // Word RAM: program region at 0xBFC00000, data region at low addresses.
    assign readdata    = (address[31:20] == 12'hBFC) ? prog[address[5:2]] : dmem[address[7:2]];
    assign waitrequest = hold_wait || (stall_en && read && wait_cnt < 3);

    always @(posedge clk) begin
        if (!reset) wait_cnt <= 0;
        else if (read && waitrequest) wait_cnt <= wait_cnt + 1;
        else if (read) wait_cnt <= 0;
        if (reset && write && !waitrequest) begin
            dmem[address[7:2]] <= writedata;
            wr_count <= wr_count + 1;
            wr_addr  <= address;
            wr_data  <= writedata;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_wait && (read !== prev_read || write !== prev_write ||
                              address !== prev_addr || writedata !== prev_wd))
                unstable <= unstable + 1;
            if (read && write) overlap <= overlap + 1;
            if (!active && (read || write)) post_halt <= post_halt + 1;
            if (waitrequest && (read || write)) stall_cnt <= stall_cnt + 1;
        end
        prev_wait  <= mon_en && waitrequest && (read || write);
        prev_read  <= read;
        prev_write <= write;
        prev_addr  <= address;
        prev_wd    <= writedata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;
    endtask

    task automatic reset_release();
        @(negedge clk) reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_halt(output int n);
        n = 0;
        while (active && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        // ADDIU $2,$0,5 ; JR $0 ; NOP
        clear_prog();
        prog[0] = 32'h24020005;
        prog[1] = 32'h00000008;
        prog[2] = 32'h00000000;
        mon_en  = 1'b1;

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_read", {31'h0, read}, 32'h0);
        check("rst_write", {31'h0, write}, 32'h0);
        check("rst_writedata", writedata, 32'h0);
        check("rst_byteenable", {28'h0, byteenable}, 32'hF);
        check("rst_active", {31'h0, active}, 32'h1);
        check("rst_v0", register_v0, 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("first_read", {31'h0, read}, 32'h1);
        check("first_addr", address, 32'hBFC00000);
        check("first_write", {31'h0, write}, 32'h0);
        run_to_halt(cyc);
        check("p1_halted", {31'h0, active}, 32'h0);
        check("p1_cycles", cyc, 32'd9);
        check("p1_v0", register_v0, 32'h5);
        snap = post_halt;
        repeat (10) @(posedge clk);
        #1;
        check("p1_no_bus_after_halt", post_halt - snap, 32'h0);

        // Same program, 3 wait states on every read
        stall_en = 1'b1;
        snap = unstable;
        cyc  = stall_cnt;
        reset_release();
        check("p2_first_addr", address, 32'hBFC00000);
        check("p2_first_wait", {31'h0, waitrequest}, 32'h1);
        begin
            int stalls0 = cyc;
            run_to_halt(cyc);
            check("p2_halted", {31'h0, active}, 32'h0);
            check("p2_cycles", cyc, 32'd18);
            check("p2_v0", register_v0, 32'h5);
            check("p2_stable", unstable - snap, 32'h0);
            check("p2_stall_cycles", stall_cnt - stalls0, 32'd9);
        end
        stall_en = 1'b0;

        // ADDIU $3,$0,0x1234 ; SW $3,0x40($0) ; LW $2,0x40($0) ; JR $0 ; NOP
        clear_prog();
        prog[0] = 32'h24031234;
        prog[1] = 32'hAC030040;
        prog[2] = 32'h8C020040;
        prog[3] = 32'h00000008;
        prog[4] = 32'h00000000;
        snap = wr_count;
        reset_release();
        begin
            int ov0 = overlap;
            run_to_halt(cyc);
            check("p3_halted", {31'h0, active}, 32'h0);
            check("p3_cycles", cyc, 32'd17);
            check("p3_wr_count", wr_count - snap, 32'd1);
            check("p3_wr_addr", wr_addr, 32'h40);
            check("p3_wr_data", wr_data, 32'h1234);
            check("p3_v0", register_v0, 32'h1234);
            check("p3_no_overlap", overlap - ov0, 32'h0);
        end

        // BEQ $0,$0,+2 ; ADDIU $2,$2,1 (slot) ; ADDIU $2,$2,10 (skipped) ; JR $0 ; NOP
        clear_prog();
        prog[0] = 32'h10000002;
        prog[1] = 32'h24420001;
        prog[2] = 32'h2442000A;
        prog[3] = 32'h00000008;
        prog[4] = 32'h00000000;
        reset_release();
        run_to_halt(cyc);
        check("p4_halted", {31'h0, active}, 32'h0);
        check("p4_cycles", cyc, 32'd12);
        check("p4_v0", register_v0, 32'h1);

        // Reset during a stalled fetch of JR (after v0 has become 1)
        mon_en = 1'b0;
        reset_release();
        cyc = 0;
        while (register_v0 !== 32'h1 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("p5_v0_set", register_v0, 32'h1);
        hold_wait = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("p5_stall_read", {31'h0, read}, 32'h1);
        check("p5_stall_addr", address, 32'hBFC0000C);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        check("p5_abort_read", {31'h0, read}, 32'h0);
        check("p5_abort_v0", register_v0, 32'h0);
        hold_wait = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("p5_restart_read", {31'h0, read}, 32'h1);
        check("p5_restart_addr", address, 32'hBFC00000);
        run_to_halt(cyc);
        check("p5_halted", {31'h0, active}, 32'h0);
        check("p5_v0", register_v0, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
